// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup, IF/ID-aligned prediction and ID write-back signals of the BTB.
// The master drives PCs and resolution results; the slave is the predictor.
interface branch_predictor_btb_if;
   logic [31:0] pc_if;
   logic        stall_if;
   logic        flush_if;
   logic        btb_hit_if;
   logic        pred_taken_if;
   logic [31:0] pred_pc_if;
   logic        btb_en;
   logic        jump;
   logic [31:0] pred_pc_id;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [15:0] mispredict_cnt;

   modport slave (
      input  pc_if, stall_if, flush_if, upd_valid, upd_pc, upd_taken, upd_target,
      output btb_hit_if, pred_taken_if, pred_pc_if, btb_en, jump, pred_pc_id, mispredict_cnt
   );

   modport master (
      output pc_if, stall_if, flush_if, upd_valid, upd_pc, upd_taken, upd_target,
      input  btb_hit_if, pred_taken_if, pred_pc_if, btb_en, jump, pred_pc_id, mispredict_cnt
   );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: zero-latency comb lookup, one-cycle IF/ID copy.
// No backpressure on write-back; stall only freezes the IF/ID copy, flush clears it.
module branch_predictor_btb #(
   parameter int IDX_W = 4
) (
   input logic                  clk,
   input logic                  rst,
   branch_predictor_btb_if.slave bus
);
   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 30 - IDX_W;

   logic [ENTRIES-1:0]             valid_q;
   logic [ENTRIES-1:0][1:0]        ctr_q;
   logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
   logic [ENTRIES-1:0][31:0]       tgt_q;

   logic        btb_en_q, btb_en_d;
   logic        jump_q, jump_d;
   logic [31:0] pred_pc_id_q, pred_pc_id_d;
   logic [15:0] mis_cnt_q, mis_cnt_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit;
   logic             unused_pc_bits;

   assign lk_idx = bus.pc_if[IDX_W+1:2];
   assign lk_tag = bus.pc_if[31:IDX_W+2];
   assign up_idx = bus.upd_pc[IDX_W+1:2];
   assign up_tag = bus.upd_pc[31:IDX_W+2];
   assign unused_pc_bits = ^{bus.pc_if[1:0], bus.upd_pc[1:0]};

   // Lookup reads registered arrays only, so a same-cycle update is seen next cycle.
   assign bus.btb_hit_if    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign bus.pred_taken_if = bus.btb_hit_if && ctr_q[lk_idx][1];
   assign bus.pred_pc_if    = bus.pred_taken_if ? tgt_q[lk_idx] : bus.pc_if + 32'd4;
   assign up_hit            = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_comb begin
      btb_en_d     = btb_en_q;
      jump_d       = jump_q;
      pred_pc_id_d = pred_pc_id_q;
      if (bus.flush_if) begin
         btb_en_d     = 1'b0;
         jump_d       = 1'b0;
         pred_pc_id_d = 32'd0;
      end else if (!bus.stall_if) begin
         btb_en_d     = bus.btb_hit_if;
         jump_d       = bus.pred_taken_if;
         pred_pc_id_d = bus.pred_pc_if;
      end
   end

   always_comb begin
      mis_cnt_d = mis_cnt_q;
      if (bus.upd_valid && (bus.upd_taken != jump_q) && (mis_cnt_q != 16'hFFFF))
         mis_cnt_d = mis_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btb_en_q     <= 1'b0;
         jump_q       <= 1'b0;
         pred_pc_id_q <= 32'd0;
         mis_cnt_q    <= 16'd0;
      end else begin
         btb_en_q     <= btb_en_d;
         jump_q       <= jump_d;
         pred_pc_id_q <= pred_pc_id_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end

   // Not-taken misses never allocate; taken misses replace whatever aliases there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         ctr_q   <= {ENTRIES{2'b01}};
         tag_q   <= '0;
         tgt_q   <= '0;
      end else if (bus.upd_valid) begin
         if (up_hit) begin
            if (bus.upd_taken) begin
               if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
               tgt_q[up_idx] <= bus.upd_target;
            end else if (ctr_q[up_idx] != 2'b00) begin
               ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
            end
         end else if (bus.upd_taken) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            tgt_q[up_idx]   <= bus.upd_target;
            ctr_q[up_idx]   <= 2'b10;
         end
      end
   end

   assign bus.btb_en         = btb_en_q;
   assign bus.jump           = jump_q;
   assign bus.pred_pc_id     = pred_pc_id_q;
   assign bus.mispredict_cnt = mis_cnt_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb with hand-computed expectations.
module tb_branch_predictor_btb;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   branch_predictor_btb_if bus ();

   branch_predictor_btb #(.IDX_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One idle cycle on a never-allocated PC forces jump=0, then one update edge.
   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      bus.pc_if     = 32'h500;
      bus.upd_valid = 1'b0;
      tick();
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_taken  = taken;
      bus.upd_target = tgt;
      tick();
      bus.upd_valid  = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                       input logic tk, input logic [31:0] npc);
      bus.pc_if = pc;
      #1;
      chk({tag, "_hit"}, {31'd0, bus.btb_hit_if}, {31'd0, hit});
      chk({tag, "_taken"}, {31'd0, bus.pred_taken_if}, {31'd0, tk});
      chk({tag, "_pc"}, bus.pred_pc_if, npc);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst            = 1'b1;
      bus.pc_if      = 32'h100;
      bus.stall_if   = 1'b0;
      bus.flush_if   = 1'b0;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = 32'd0;
      bus.upd_taken  = 1'b0;
      bus.upd_target = 32'd0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // reset state and cold lookup
      #1;
      chk("rst_btb_en", {31'd0, bus.btb_en}, 32'd0);
      chk("rst_jump", {31'd0, bus.jump}, 32'd0);
      chk("rst_pred_pc_id", bus.pred_pc_id, 32'd0);
      chk("rst_cnt", {16'd0, bus.mispredict_cnt}, 32'd0);
      look("cold", 32'h100, 1'b0, 1'b0, 32'h104);
      tick();
      chk("cold_btb_en", {31'd0, bus.btb_en}, 32'd0);
      chk("cold_jump", {31'd0, bus.jump}, 32'd0);
      chk("cold_pred_pc_id", bus.pred_pc_id, 32'h104);

      // allocate on taken miss, ctr=10
      upd(32'h100, 1'b1, 32'h200);
      look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
      tick();
      chk("alloc_btb_en", {31'd0, bus.btb_en}, 32'd1);
      chk("alloc_jump", {31'd0, bus.jump}, 32'd1);
      chk("alloc_pred_pc_id", bus.pred_pc_id, 32'h200);
      chk("cnt_after_alloc", {16'd0, bus.mispredict_cnt}, 32'd1);

      // counter walk: 10->01->00->00->01->10->11->11->10->01
      upd(32'h100, 1'b0, 32'h0);  look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
      upd(32'h100, 1'b0, 32'h0);  look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
      upd(32'h100, 1'b0, 32'h0);  look("nt3", 32'h100, 1'b1, 1'b0, 32'h104);
      upd(32'h100, 1'b1, 32'h200); look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
      upd(32'h100, 1'b1, 32'h200); look("t2", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b1, 32'h240); look("t3", 32'h100, 1'b1, 1'b1, 32'h240);
      upd(32'h100, 1'b1, 32'h240); look("t4", 32'h100, 1'b1, 1'b1, 32'h240);
      upd(32'h100, 1'b0, 32'h0);  look("nt4", 32'h100, 1'b1, 1'b1, 32'h240);
      upd(32'h100, 1'b0, 32'h0);  look("nt5", 32'h100, 1'b1, 1'b0, 32'h104);
      chk("cnt_after_walk", {16'd0, bus.mispredict_cnt}, 32'd5);

      // aliasing replaces the entry at index 0
      upd(32'h140, 1'b1, 32'h300);
      look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
      look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
      chk("cnt_after_alias", {16'd0, bus.mispredict_cnt}, 32'd6);

      // same-cycle update and lookup: no bypass
      bus.pc_if = 32'h500;
      tick();
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 32'h100;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 32'h200;
      look("same_pre", 32'h100, 1'b0, 1'b0, 32'h104);
      tick();
      bus.upd_valid = 1'b0;
      chk("same_btb_en", {31'd0, bus.btb_en}, 32'd0);
      look("same_post", 32'h100, 1'b1, 1'b1, 32'h200);
      chk("cnt_after_same", {16'd0, bus.mispredict_cnt}, 32'd7);

      // stall holds, release loads, flush beats stall
      bus.stall_if = 1'b1;
      tick();
      chk("stall_btb_en", {31'd0, bus.btb_en}, 32'd0);
      chk("stall_pred_pc_id", bus.pred_pc_id, 32'h104);
      bus.stall_if = 1'b0;
      tick();
      chk("load_btb_en", {31'd0, bus.btb_en}, 32'd1);
      chk("load_jump", {31'd0, bus.jump}, 32'd1);
      chk("load_pred_pc_id", bus.pred_pc_id, 32'h200);
      bus.stall_if = 1'b1;
      bus.flush_if = 1'b1;
      tick();
      chk("flush_btb_en", {31'd0, bus.btb_en}, 32'd0);
      chk("flush_jump", {31'd0, bus.jump}, 32'd0);
      chk("flush_pred_pc_id", bus.pred_pc_id, 32'd0);
      bus.stall_if = 1'b0;
      bus.flush_if = 1'b0;

      // saturate the mispredict counter: jump stays 0 on pc 0x504
      bus.pc_if = 32'h504;
      tick();
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 32'h600;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 32'h700;
      repeat (16'hFFFF - 7) tick();
      chk("cnt_reach_max", {16'd0, bus.mispredict_cnt}, 32'hFFFF);
      repeat (3) tick();
      chk("cnt_hold_max", {16'd0, bus.mispredict_cnt}, 32'hFFFF);
      bus.upd_valid = 1'b0;

      look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      look("pc600", 32'h600, 1'b1, 1'b1, 32'h700);
      tick();
      chk("pre_rst_btb_en", {31'd0, bus.btb_en}, 32'd1);

      // async reset with an update pending: all state cleared at once
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 32'h504;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 32'h900;
      rst = 1'b1;
      #1;
      chk("arst_btb_en", {31'd0, bus.btb_en}, 32'd0);
      chk("arst_jump", {31'd0, bus.jump}, 32'd0);
      chk("arst_pred_pc_id", bus.pred_pc_id, 32'd0);
      chk("arst_cnt", {16'd0, bus.mispredict_cnt}, 32'd0);
      look("arst_lookup", 32'h600, 1'b0, 1'b0, 32'h604);
      tick();
      rst = 1'b0;
      bus.upd_valid = 1'b0;
      tick();
      look("arst_discard", 32'h504, 1'b0, 1'b0, 32'h508);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
